// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready on both sides and flush.
// Latency: 1 cycle (PASS_THRU=0); 0 cycles when empty with PASS_THRU=1.
// Backpressure: in_ready depends only on stored count, flush and reset, never on out_ready.
module pipe_stage_fifo #(
  parameter int DATA_W    = 200,
  parameter int DEPTH     = 2,
  parameter int PASS_THRU = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit PT = (PASS_THRU != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              fwd;
  logic              push;
  logic              pop;
  logic              bypass;
  logic              store;
  logic              take;

  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    fwd      = PT && empty;
    in_ready = ~full & ~flush & ~reset;
    if (fwd) begin
      out_valid = in_valid & ~flush & ~reset;
      out_data  = in_data;
    end else begin
      out_valid = ~empty & ~flush & ~reset;
      out_data  = mem[rd_ptr];
    end
    push   = in_valid & in_ready;
    pop    = out_valid & out_ready;
    // A forwarded beat consumed in the same cycle never touches storage.
    bypass = fwd & push & pop;
    store  = push & ~bypass;
    take   = pop & ~bypass;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (take) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(store) - CW'(take);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty && !fwd));
  a_count_range:  assert property (@(posedge clk) count <= CW'(DEPTH));

endmodule
